// File: rtl/fmq_pkg.sv
// Shared definitions for the transducer-board command initiator: op codes,
// error codes, frame header bytes and the controller state encoding.
package fmq_pkg;

   localparam logic [2:0] OP_OFFSET  = 3'd0;
   localparam logic [2:0] OP_DIVISOR = 3'd1;
   localparam logic [2:0] OP_QUERY   = 3'd2;
   localparam logic [2:0] OP_DAC     = 3'd3;
   localparam logic [2:0] OP_RELOAD  = 3'd4;
   localparam logic [2:0] OP_VERSION = 3'd5;

   localparam logic [2:0] ERR_OK      = 3'd0;
   localparam logic [2:0] ERR_ECHO    = 3'd1;
   localparam logic [2:0] ERR_TIMEOUT = 3'd2;
   localparam logic [2:0] ERR_OP      = 3'd3;
   localparam logic [2:0] ERR_CHAN    = 3'd4;

   localparam logic [7:0] HDR_QUERY   = 8'hC0;
   localparam logic [7:0] HDR_DAC     = 8'hE0;
   localparam logic [7:0] HDR_VERSION = 8'hE8;
   localparam logic [7:0] HDR_RELOAD  = 8'hF0;

   localparam int BYTES_PER_CMD = 3;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_LOAD       = 3'd1,
      S_SEND       = 3'd2,
      S_WAIT_ECHO  = 3'd3,
      S_WAIT_REPLY = 3'd4,
      S_FINISH     = 3'd5
   } fmq_state_e;

   // Byte 0 is the header and travels first on the wire.
   function automatic logic [7:0] frame_byte(input logic [23:0] frame, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = frame[23:16];
         2'd1:    b = frame[15:8];
         default: b = frame[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/fmq_cmd_encode.sv
// Combinational mapping of one request onto its 3-byte command frame,
// together with the legality flags the controller acts on.
module fmq_cmd_encode
   import fmq_pkg::*;
#(
   parameter int NUM_OUTPUTS = 88
) (
   input  logic [2:0]  i_op,
   input  logic [6:0]  i_chan,
   input  logic [18:0] i_data,
   output logic [23:0] o_frame,
   output logic        o_op_illegal,
   output logic        o_chan_bad
);

   // Frame builder: header carries bit 7 set, payload bytes keep bit 7 clear.
   always_comb begin
      o_frame = 24'h000000;
      case (i_op)
         OP_OFFSET:  o_frame = {1'b1, 2'b00, i_chan[6:2], 1'b0, i_chan[1:0], i_data[11:7], 1'b0, i_data[6:0]};
         OP_DIVISOR: o_frame = {1'b1, 2'b01, i_data[18:14], 1'b0, i_data[13:7], 1'b0, i_data[6:0]};
         OP_QUERY:   o_frame = {HDR_QUERY, 16'h0000};
         OP_DAC:     o_frame = {HDR_DAC, 1'b0, 5'b00000, i_data[8:7], 1'b0, i_data[6:0]};
         OP_RELOAD:  o_frame = {HDR_RELOAD, 16'h0000};
         OP_VERSION: o_frame = {HDR_VERSION, 16'h0000};
         default:    o_frame = 24'h000000;
      endcase
   end

   assign o_op_illegal = (i_op > OP_VERSION);
   assign o_chan_bad   = (i_op == OP_OFFSET) && ({25'd0, i_chan} >= 32'(NUM_OUTPUTS));

endmodule

// File: rtl/fmq_cmd_tx.sv
// Host-side command initiator: sends one 3-byte frame a byte at a time,
// checks every echo, optionally captures a reply byte and reports status.
module fmq_cmd_tx
   import fmq_pkg::*;
#(
   parameter int NUM_OUTPUTS = 88,
   parameter int TIMEOUT     = 50000,
   parameter int TO_WIDTH    = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [6:0]  req_chan,
   input  logic [18:0] req_data,
   output logic [7:0]  tx_tdata,
   output logic        tx_tvalid,
   input  logic        tx_tready,
   input  logic [7:0]  rx_tdata,
   input  logic        rx_tvalid,
   output logic        rx_tready,
   output logic        busy,
   output logic        done,
   output logic [2:0]  err_code,
   output logic [7:0]  resp_data
);

   localparam logic [TO_WIDTH-1:0] TO_LAST  = TO_WIDTH'(TIMEOUT - 1);
   localparam logic [1:0]          IDX_LAST = 2'(BYTES_PER_CMD - 1);

   fmq_state_e          r_state, w_state_nxt;
   logic [2:0]          r_op;
   logic [6:0]          r_chan;
   logic [18:0]         r_data;
   logic [1:0]          r_idx, w_idx_nxt;
   logic [TO_WIDTH-1:0] r_cnt, w_cnt_nxt;
   logic [2:0]          r_err, w_err_nxt;
   logic [7:0]          r_resp, w_resp_nxt;
   logic [7:0]          r_tx_tdata;
   logic                r_tx_tvalid, r_rx_tready, r_req_ready, r_busy, r_done;
   logic [23:0]         w_frame;
   logic                w_op_illegal, w_chan_bad;
   logic                w_req_hs, w_tx_hs, w_rx_hs, w_timeout, w_has_reply;

   fmq_cmd_encode #(.NUM_OUTPUTS(NUM_OUTPUTS)) u_encode (
      .i_op         (r_op),
      .i_chan       (r_chan),
      .i_data       (r_data),
      .o_frame      (w_frame),
      .o_op_illegal (w_op_illegal),
      .o_chan_bad   (w_chan_bad)
   );

   assign w_req_hs    = r_req_ready & req_valid;
   assign w_tx_hs     = r_tx_tvalid & tx_tready;
   assign w_rx_hs     = r_rx_tready & rx_tvalid;
   assign w_timeout   = (r_cnt == TO_LAST);
   assign w_has_reply = (r_op == OP_QUERY) || (r_op == OP_VERSION);

   // Next-state logic; a byte arriving in the final timeout cycle still counts.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt;
      w_err_nxt   = r_err;
      w_resp_nxt  = r_resp;
      case (r_state)
         S_IDLE: begin
            if (w_req_hs) w_state_nxt = S_LOAD;
            else          w_state_nxt = S_IDLE;
         end
         S_LOAD: begin
            if (w_op_illegal) begin
               w_err_nxt   = ERR_OP;
               w_state_nxt = S_FINISH;
            end else if (w_chan_bad) begin
               w_err_nxt   = ERR_CHAN;
               w_state_nxt = S_FINISH;
            end else begin
               w_idx_nxt   = 2'd0;
               w_state_nxt = S_SEND;
            end
         end
         S_SEND: begin
            if (w_tx_hs) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_WAIT_ECHO;
            end else begin
               w_state_nxt = S_SEND;
            end
         end
         S_WAIT_ECHO: begin
            if (w_rx_hs) begin
               if (rx_tdata != frame_byte(w_frame, r_idx)) begin
                  w_err_nxt   = ERR_ECHO;
                  w_state_nxt = S_FINISH;
               end else if (r_idx != IDX_LAST) begin
                  w_idx_nxt   = r_idx + 2'd1;
                  w_state_nxt = S_SEND;
               end else if (w_has_reply) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_WAIT_REPLY;
               end else begin
                  w_err_nxt   = ERR_OK;
                  w_state_nxt = S_FINISH;
               end
            end else if (w_timeout) begin
               w_err_nxt   = ERR_TIMEOUT;
               w_state_nxt = S_FINISH;
            end else begin
               w_cnt_nxt   = r_cnt + TO_WIDTH'(1);
            end
         end
         S_WAIT_REPLY: begin
            if (w_rx_hs) begin
               w_resp_nxt  = rx_tdata;
               w_err_nxt   = ERR_OK;
               w_state_nxt = S_FINISH;
            end else if (w_timeout) begin
               w_err_nxt   = ERR_TIMEOUT;
               w_state_nxt = S_FINISH;
            end else begin
               w_cnt_nxt   = r_cnt + TO_WIDTH'(1);
            end
         end
         S_FINISH: w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // State, request capture and outputs registered from the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_op        <= 3'd0;
         r_chan      <= 7'd0;
         r_data      <= 19'd0;
         r_idx       <= 2'd0;
         r_cnt       <= '0;
         r_err       <= ERR_OK;
         r_resp      <= 8'h00;
         r_tx_tdata  <= 8'h00;
         r_tx_tvalid <= 1'b0;
         r_rx_tready <= 1'b0;
         r_req_ready <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_idx       <= w_idx_nxt;
         r_cnt       <= w_cnt_nxt;
         r_err       <= w_err_nxt;
         r_resp      <= w_resp_nxt;
         if (w_req_hs) begin
            r_op   <= req_op;
            r_chan <= req_chan;
            r_data <= req_data;
         end
         if (w_state_nxt == S_SEND) r_tx_tdata <= frame_byte(w_frame, w_idx_nxt);
         r_tx_tvalid <= (w_state_nxt == S_SEND);
         r_rx_tready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_WAIT_ECHO) ||
                        (w_state_nxt == S_WAIT_REPLY);
         r_req_ready <= (w_state_nxt == S_IDLE);
         r_busy      <= (w_state_nxt != S_IDLE);
         r_done      <= (w_state_nxt == S_FINISH);
      end
   end

   assign req_ready = r_req_ready;
   assign tx_tdata  = r_tx_tdata;
   assign tx_tvalid = r_tx_tvalid;
   assign rx_tready = r_rx_tready;
   assign busy      = r_busy;
   assign done      = r_done;
   assign err_code  = r_err;
   assign resp_data = r_resp;

endmodule

// File: tb/tb_fmq_cmd_tx.sv
// Scoreboard bench for fmq_cmd_tx: a board model answers each byte, expected
// bytes and results are queued at issue time and checked by a monitor.
module tb_fmq_cmd_tx;

   localparam int TO = 40;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_op = 3'd0;
   logic [6:0]  req_chan = 7'd0;
   logic [18:0] req_data = 19'd0;
   logic [7:0]  tx_tdata;
   logic        tx_tvalid;
   logic        tx_tready = 1'b0;
   logic [7:0]  rx_tdata = 8'h00;
   logic        rx_tvalid = 1'b0;
   logic        rx_tready;
   logic        busy;
   logic        done;
   logic [2:0]  err_code;
   logic [7:0]  resp_data;

   typedef struct {
      logic [2:0] err;
      logic       chk_resp;
      logic [7:0] resp;
   } res_t;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] exp_tx_q[$];
   res_t       exp_res_q[$];
   logic       stall = 1'b0;

   fmq_cmd_tx #(.NUM_OUTPUTS(88), .TIMEOUT(TO), .TO_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_chan(req_chan), .req_data(req_data),
      .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
      .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tready(rx_tready),
      .busy(busy), .done(done), .err_code(err_code), .resp_data(resp_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference frame derived directly from the protocol's byte layout.
   function automatic void model_frame(input int op, input int chan, input int data, output int b[3]);
      b[0] = 0; b[1] = 0; b[2] = 0;
      case (op)
         0: begin b[0] = 128 + chan / 4; b[1] = (chan % 4) * 32 + (data / 128) % 32; b[2] = data % 128; end
         1: begin b[0] = 160 + (data / 16384) % 32; b[1] = (data / 128) % 128; b[2] = data % 128; end
         2: b[0] = 192;
         3: begin b[0] = 224; b[1] = (data / 128) % 4; b[2] = data % 128; end
         4: b[0] = 240;
         5: b[0] = 232;
         default: b[0] = 0;
      endcase
   endfunction

   // UART side of the link accepts bytes at random.
   initial forever begin
      @(posedge clk); #1;
      tx_tready = stall ? 1'b0 : ($urandom_range(3) != 0);
   end

   // Monitor: compares every sent byte and every completion against the queues.
   initial begin
      logic       prev_hold = 1'b0;
      logic [7:0] prev_data = 8'h00;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_hold = 1'b0;
         end else begin
            if (prev_hold) begin
               check("tx_valid_held", {31'd0, tx_tvalid}, 32'd1);
               check("tx_data_stable", {24'd0, tx_tdata}, {24'd0, prev_data});
            end
            prev_hold = tx_tvalid && !tx_tready;
            prev_data = tx_tdata;
            if (tx_tvalid && tx_tready) begin
               if (exp_tx_q.size() == 0) check("unexpected_tx", {24'd0, tx_tdata}, 32'hFFFF_FFFF);
               else check("tx_byte", {24'd0, tx_tdata}, {24'd0, exp_tx_q.pop_front()});
            end
            if (done) begin
               if (exp_res_q.size() == 0) begin
                  check("unexpected_done", 32'd1, 32'd0);
               end else begin
                  res_t r;
                  r = exp_res_q.pop_front();
                  check("err_code", {29'd0, err_code}, {29'd0, r.err});
                  if (r.chk_resp) check("resp_data", {24'd0, resp_data}, {24'd0, r.resp});
               end
            end
         end
      end
   end

   task automatic send_rx(input logic [7:0] d, output bit ok);
      ok = 1'b0;
      rx_tvalid = 1'b1;
      rx_tdata  = d;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (rx_tready) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      rx_tvalid = 1'b0;
      rx_tdata  = 8'($urandom);
   endtask

   // mode 0: clean; 1: echo of byte midx corrupted; 2: byte midx (3 = reply) never answered.
   task automatic run_req(input int op, input int chan, input int data, input int mode,
                          input int midx, input int stall_cyc, input logic [7:0] reply);
      int   b[3];
      int   nbytes, lat, exp_lat;
      bit   legal, has_reply, ok;
      res_t r;
      model_frame(op, chan, data, b);
      legal     = (op <= 5) && !(op == 0 && chan >= 88);
      has_reply = (op == 2 || op == 5);
      if (!legal) nbytes = 0;
      else if (mode != 0 && midx < 3) nbytes = midx + 1;
      else nbytes = 3;
      for (int i = 0; i < nbytes; i++) exp_tx_q.push_back(8'(b[i]));
      if (op > 5) r.err = 3'd3;
      else if (!legal) r.err = 3'd4;
      else r.err = 3'(mode);
      r.chk_resp = legal && (mode == 0) && has_reply;
      r.resp     = reply;
      exp_res_q.push_back(r);
      exp_lat = (!legal) ? 2 : (mode == 2) ? TO + 1 : 1;

      @(posedge clk); #1;
      if (req_ready && $urandom_range(3) == 0) begin
         rx_tvalid = 1'b1; rx_tdata = 8'($urandom);
         @(posedge clk); #1;
         rx_tvalid = 1'b0;
      end
      if (stall_cyc > 0) begin stall = 1'b1; @(posedge clk); #1; end
      req_valid = 1'b1; req_op = 3'(op); req_chan = 7'(chan); req_data = 19'(data);
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (req_ready) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      req_valid = 1'b0; req_op = 3'($urandom); req_chan = 7'($urandom); req_data = 19'($urandom);
      if (!ok) check("req_accept_timeout", 32'd0, 32'd1);
      if (stall_cyc > 0) begin
         repeat (stall_cyc) @(posedge clk);
         #1;
         check("stall_tvalid", {31'd0, tx_tvalid}, 32'd1);
         check("stall_tdata", {24'd0, tx_tdata}, 32'(b[0]));
         check("stall_no_done", {31'd0, done}, 32'd0);
         stall = 1'b0;
      end
      for (int i = 0; i < nbytes && ok; i++) begin
         ok = 1'b0;
         for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (tx_tvalid && tx_tready) begin ok = 1'b1; break; end
         end
         @(posedge clk); #1;
         if (!ok) begin check("tx_wait_timeout", 32'd0, 32'd1); break; end
         if (mode == 2 && i == midx) break;
         repeat ($urandom_range(2)) begin @(posedge clk); #1; end
         send_rx(8'(b[i]) ^ ((mode == 1 && i == midx) ? 8'h01 : 8'h00), ok);
         if (!ok) check("echo_accept_timeout", 32'd0, 32'd1);
      end
      if (ok && legal && has_reply && mode == 0) begin
         repeat ($urandom_range(2)) begin @(posedge clk); #1; end
         send_rx(reply, ok);
         if (!ok) check("reply_accept_timeout", 32'd0, 32'd1);
      end
      lat = 0;
      for (int c = 1; c < TO + 100; c++) begin
         @(negedge clk);
         if (done) begin lat = c; break; end
      end
      check("done_latency", 32'(lat), 32'(exp_lat));
      @(posedge clk); #1;
   endtask

   initial begin
      bit ok;
      #23;
      check("rst_tx_tvalid", {31'd0, tx_tvalid}, 32'd0);
      check("rst_rx_tready", {31'd0, rx_tready}, 32'd0);
      check("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check("rst_busy_done", {30'd0, busy, done}, 32'd0);
      check("rst_err_resp", {21'd0, err_code, resp_data}, 32'd0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("idle_req_ready", {31'd0, req_ready}, 32'd1);
      check("idle_busy", {31'd0, busy}, 32'd0);

      run_req(0, 5, 'h801, 0, 0, 0, 8'h00);
      run_req(1, 0, 100, 0, 0, 0, 8'h00);
      run_req(3, 0, 256, 0, 0, 0, 8'h00);
      run_req(5, 0, 0, 0, 0, 0, 8'h07);
      run_req(2, 0, 0, 0, 0, 0, 8'h58);
      run_req(0, 5, 'h801, 1, 1, 0, 8'h00);
      run_req(0, 5, 'h801, 2, 0, 0, 8'h00);
      run_req(2, 0, 0, 2, 3, 0, 8'h00);
      run_req(7, 3, 0, 0, 0, 0, 8'h00);
      run_req(0, 88, 'hFFF, 0, 0, 0, 8'h00);
      run_req(0, 87, 'h7FF, 0, 0, 0, 8'h00);
      run_req(1, 0, 'h7FFFF, 0, 0, 2 * TO, 8'h00);

      for (int n = 0; n < 40; n++) begin
         int op, chan, mode, midx, sel;
         op   = $urandom_range(7);
         chan = ($urandom_range(7) == 0) ? $urandom_range(127, 88) : $urandom_range(87);
         sel  = $urandom_range(9);
         mode = (sel == 0) ? 1 : (sel == 1) ? 2 : 0;
         midx = $urandom_range((mode == 2 && (op == 2 || op == 5)) ? 3 : 2);
         run_req(op, chan, int'($urandom_range(524287)), mode, midx, 0, 8'($urandom));
      end

      // Abort a frame while the board echo is still outstanding.
      exp_tx_q.push_back(8'h81);
      @(posedge clk); #1;
      req_valid = 1'b1; req_op = 3'd0; req_chan = 7'd5; req_data = 19'h801;
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (req_ready) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int c = 0; c < 300 && ok; c++) begin
         @(negedge clk);
         if (tx_tvalid && tx_tready) break;
      end
      @(posedge clk); #3;
      check("abort_in_wait_echo", {31'd0, rx_tready}, 32'd1);
      rst = 1'b0;
      #1;
      check("abort_tx_tvalid", {31'd0, tx_tvalid}, 32'd0);
      check("abort_tx_tdata", {24'd0, tx_tdata}, 32'd0);
      check("abort_rx_req_ready", {30'd0, rx_tready, req_ready}, 32'd0);
      check("abort_busy_done", {30'd0, busy, done}, 32'd0);
      check("abort_err_resp", {21'd0, err_code, resp_data}, 32'd0);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("post_abort_idle", {30'd0, req_ready, busy}, 32'd2);
      check("tx_queue_drained", 32'(exp_tx_q.size()), 32'd0);
      check("res_queue_drained", 32'(exp_res_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
